clk_rate_detector: RTL
======================

CLK_RATE_DETECTOR -- requirements
Module: clk_rate_detector

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 12_000_000, meaning cycles without a rising edge before loss-of-clock is declared.
REQ-002 SHALL have parameter LOCK_COUNT, default 2, meaning consecutive in-window matching periods needed to assert rate_valid.
REQ-003 SHALL have port clk_10MHz  input  1  system clock, 10 MHz.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clk_in  input  1  slow clock under test, asynchronous to clk_10MHz.
REQ-006 SHALL have port rate_code  output  2  detected rate: 00=1 Hz, 01=2 Hz, 10=10 Hz, 11=50 Hz.
REQ-007 SHALL have port rate_valid  output  1  high while locked to one rate.
REQ-008 SHALL have port rate_err  output  1  high if the last period was out of all windows, or on timeout.
REQ-009 SHALL have port period  output  24  last measured period, in clk_10MHz cycles.
REQ-010 SHALL have port meas_stb  output  1  one-cycle pulse when period/rate_err update.

Function
REQ-011 clk_in SHALL pass a 2-flop synchronizer; the edge pulse SHALL be asserted for one cycle, the cycle after synchronizer stage 2 goes 0->1.
REQ-012 Period SHALL be the distance in clk_10MHz cycles between consecutive edge pulses, measured with a 24-bit counter cleared on every edge pulse.
REQ-013 Nominal periods SHALL be 10_000_000 (00), 5_000_000 (01), 1_000_000 (10), 200_000 (11); the matching windows SHALL be nominal +/-1%, inclusive: [9_900_000..10_100_000], [4_950_000..5_050_000], [990_000..1_010_000], [198_000..202_000].
REQ-014 FSM states SHALL be IDLE (no reference edge), MEASURE (counting, not locked), LOCKED.
REQ-015 IDLE: the first edge pulse SHALL clear the counter, enter MEASURE, and SHALL NOT produce meas_stb.
REQ-016 MEASURE/LOCKED, on an edge pulse: period SHALL load, meas_stb SHALL pulse in the same cycle as the period update, and rate_err SHALL be 1 if no window matches, else 0.
REQ-017 Match counter: it SHALL increment when the code equals the previous matched code, reset to 1 on a different matching code, and reset to 0 on no match.
REQ-018 When the match counter reaches LOCK_COUNT, the FSM SHALL go to LOCKED, set rate_valid=1, and load rate_code.
REQ-019 LOCKED: an out-of-window period or a different-code period SHALL clear rate_valid and return to MEASURE in the same cycle as meas_stb; rate_code SHALL hold its last value.
REQ-020 Timeout: when the counter reaches TIMEOUT_CYC in MEASURE or LOCKED, the FSM SHALL go to IDLE, rate_valid=0, rate_err=1, and meas_stb SHALL pulse once; the counter SHALL saturate and not wrap.
REQ-021 An edge pulse and a timeout in the same cycle: the edge SHALL win.
REQ-022 rate_err SHALL clear only on the next in-window measurement.
REQ-023 The counter SHALL never wrap; 24 bits covers TIMEOUT_CYC.

Reset
REQ-024 On rstn low, all flops SHALL clear asynchronously: state=IDLE, rate_code=00, rate_valid=0, rate_err=0, period=0, meas_stb=0, synchronizer=0, match count=0.
REQ-025 Reset asserted mid-measurement SHALL discard the partial count; after release, the first edge SHALL be treated per REQ-015.

Structure
REQ-026 Package clk_rate_pkg SHALL hold the rate-code constants, the nominal/min/max window constants, and the state encoding.
REQ-027 Sub-module sync_edge_det (2-flop synchronizer plus rising-edge pulse) SHALL be instantiated once; classification and the FSM SHALL stay in clk_rate_detector.

Verification
REQ-028 The bench SHALL cover: clk_in 2 Hz (period 5_000_000 cycles) -> first meas_stb period=5_000_000, rate_err=0; after 2nd period rate_valid=1, rate_code=01.
REQ-029 The bench SHALL cover: 50 Hz locked, then switch to 10 Hz -> first 1_000_000 period drops rate_valid; next period relocks with rate_code=10.
REQ-030 The bench SHALL cover: period 1_050_000 -> rate_err=1, rate_valid=0, period=1_050_000; then two 1_000_000 periods -> rate_err=0, rate_valid=1, code=10.
REQ-031 The bench SHALL cover: window boundaries 198_000 and 202_000 match code 11; 197_999 and 202_001 -> rate_err=1.
REQ-032 The bench SHALL cover: 1 Hz locked, then clk_in stuck low -> exactly 12_000_000 cycles after the last edge, meas_stb pulses, rate_err=1, rate_valid=0, state IDLE.
REQ-033 The bench SHALL cover: rstn pulsed low mid-period while locked -> all outputs 0 immediately; the first post-reset edge gives no meas_stb.

Source files
------------

// File: rtl/clk_rate_pkg.sv
// -----------------------------------------------------------------------------
// clk_rate_pkg
// Shared definitions for the slow-clock rate detector:
//   - rate codes (00=1 Hz, 01=2 Hz, 10=10 Hz, 11=50 Hz)
//   - nominal periods and +/-1% inclusive windows, in 10 MHz cycles
//   - FSM state encoding
//   - classify(): maps a measured period onto a rate code, or reports no hit
// -----------------------------------------------------------------------------
package clk_rate_pkg;

    localparam int CNT_W = 24;

    typedef enum logic [1:0] {
        RATE_1HZ  = 2'b00,
        RATE_2HZ  = 2'b01,
        RATE_10HZ = 2'b10,
        RATE_50HZ = 2'b11
    } rate_code_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // no reference edge yet
        ST_MEASURE = 2'd1,  // counting, not locked
        ST_LOCKED  = 2'd2   // LOCK_COUNT matching periods seen
    } state_e;

    // Nominal periods in clk_10MHz cycles.
    localparam int unsigned NOM_1HZ  = 10_000_000;
    localparam int unsigned NOM_2HZ  = 5_000_000;
    localparam int unsigned NOM_10HZ = 1_000_000;
    localparam int unsigned NOM_50HZ = 200_000;

    // Inclusive +/-1% windows.
    localparam int unsigned MIN_1HZ  = NOM_1HZ  - NOM_1HZ  / 100;
    localparam int unsigned MAX_1HZ  = NOM_1HZ  + NOM_1HZ  / 100;
    localparam int unsigned MIN_2HZ  = NOM_2HZ  - NOM_2HZ  / 100;
    localparam int unsigned MAX_2HZ  = NOM_2HZ  + NOM_2HZ  / 100;
    localparam int unsigned MIN_10HZ = NOM_10HZ - NOM_10HZ / 100;
    localparam int unsigned MAX_10HZ = NOM_10HZ + NOM_10HZ / 100;
    localparam int unsigned MIN_50HZ = NOM_50HZ - NOM_50HZ / 100;
    localparam int unsigned MAX_50HZ = NOM_50HZ + NOM_50HZ / 100;

    typedef struct packed {
        logic       hit;
        rate_code_e code;
    } class_t;

    // div scales the whole time base down; every window bound above is an
    // exact multiple of 2000, so any divisor of 2000 keeps the windows exact.
    function automatic logic in_win(input logic [CNT_W-1:0] p,
                                    input int unsigned      lo,
                                    input int unsigned      hi,
                                    input int unsigned      div);
        logic [31:0] pw;
        pw = {{(32-CNT_W){1'b0}}, p};
        return (pw >= lo / div) && (pw <= hi / div);
    endfunction

    function automatic class_t classify(input logic [CNT_W-1:0] p,
                                        input int unsigned      div);
        class_t r;
        r.hit  = 1'b1;
        r.code = RATE_1HZ;
        if (in_win(p, MIN_1HZ, MAX_1HZ, div))        r.code = RATE_1HZ;
        else if (in_win(p, MIN_2HZ, MAX_2HZ, div))   r.code = RATE_2HZ;
        else if (in_win(p, MIN_10HZ, MAX_10HZ, div)) r.code = RATE_10HZ;
        else if (in_win(p, MIN_50HZ, MAX_50HZ, div)) r.code = RATE_50HZ;
        else                                         r.hit  = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchronizer for an asynchronous slow signal plus a rising-edge
// detector. rise is high for exactly one clk_10MHz cycle: the cycle after
// synchronizer stage 2 goes 0->1.
// Ports:
//   clk_10MHz  in   system clock
//   rstn       in   asynchronous active-low reset
//   sig_async  in   signal to be synchronized
//   rise       out  one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk_10MHz,
    input  logic rstn,
    input  logic sig_async,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_2_d;

    // NOTE: non-blocking assignments let every flop sample the pre-edge value,
    // so the three stages shift by one per clock regardless of statement order.
    always_ff @(posedge clk_10MHz or negedge rstn) begin
        if (!rstn) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            sync_2_d <= 1'b0;
        end else begin
            sync_1   <= sig_async;
            sync_2   <= sync_1;
            sync_2_d <= sync_2;
        end
    end

    assign rise = sync_2 & ~sync_2_d;

endmodule

// File: rtl/clk_rate_detector.sv
// -----------------------------------------------------------------------------
// clk_rate_detector
// Measures the period of a slow asynchronous clock (1/2/10/50 Hz) in
// clk_10MHz cycles, classifies it against +/-1% windows and locks after
// LOCK_COUNT consecutive matching periods. Declares loss-of-clock after
// TIMEOUT_CYC cycles without an edge.
// Parameters:
//   TIMEOUT_CYC  cycles without an edge before loss-of-clock
//   LOCK_COUNT   consecutive matching periods needed to lock
//   RATE_DIV     time-base divisor applied to all windows (1 = real rates)
// Ports:
//   clk_10MHz   in   system clock
//   rstn        in   asynchronous active-low reset
//   clk_in      in   slow clock under test
//   rate_code   out  detected rate, held while unlocked
//   rate_valid  out  high while locked
//   rate_err    out  last period out of all windows, or timeout
//   period      out  last measured period
//   meas_stb    out  one-cycle pulse when period/rate_err update
// -----------------------------------------------------------------------------
module clk_rate_detector
    import clk_rate_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 12_000_000,
    parameter int unsigned LOCK_COUNT  = 2,
    parameter int unsigned RATE_DIV    = 1
) (
    input  logic        clk_10MHz,
    input  logic        rstn,
    input  logic        clk_in,
    output logic [1:0]  rate_code,
    output logic        rate_valid,
    output logic        rate_err,
    output logic [23:0] period,
    output logic        meas_stb
);

    localparam int                MC_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT = CNT_W'(TIMEOUT_CYC);
    localparam logic [MC_W-1:0]   LOCK_N  = MC_W'(LOCK_COUNT);

    logic             edge_pulse;
    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [MC_W-1:0]  match_cnt;
    rate_code_e       last_code;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] meas;
    class_t           cls;
    logic [MC_W-1:0]  match_next;

    sync_edge_det u_sync (
        .clk_10MHz (clk_10MHz),
        .rstn      (rstn),
        .sig_async (clk_in),
        .rise      (edge_pulse)
    );

    // The counter is cleared on the edge-pulse cycle, so on the next edge it
    // holds period-1; meas adds that edge cycle back in.
    // NOTE: every always_comb output gets a value before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_inc    = (cnt >= TIMEOUT) ? cnt : cnt + CNT_W'(1);
        meas       = cnt + CNT_W'(1);
        cls        = classify(meas, RATE_DIV);
        match_next = '0;
        if (cls.hit) begin
            if (cls.code == last_code)
                match_next = (match_cnt >= LOCK_N) ? match_cnt : match_cnt + MC_W'(1);
            else
                match_next = MC_W'(1);
        end
    end

    always_ff @(posedge clk_10MHz or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            match_cnt  <= '0;
            last_code  <= RATE_1HZ;
            rate_code  <= 2'b00;
            rate_valid <= 1'b0;
            rate_err   <= 1'b0;
            period     <= '0;
            meas_stb   <= 1'b0;
        end else begin
            meas_stb <= 1'b0;
            cnt      <= cnt_inc;
            case (state)
                ST_IDLE: begin
                    // First edge only establishes the reference point.
                    if (edge_pulse) begin
                        cnt   <= '0;
                        state <= ST_MEASURE;
                    end
                end
                default: begin
                    // Edge takes priority over a coincident timeout.
                    if (edge_pulse) begin
                        cnt       <= '0;
                        period    <= meas;
                        meas_stb  <= 1'b1;
                        rate_err  <= ~cls.hit;
                        match_cnt <= match_next;
                        if (cls.hit)
                            last_code <= cls.code;
                        if (!cls.hit || (state == ST_LOCKED && cls.code != rate_code)) begin
                            state      <= ST_MEASURE;
                            rate_valid <= 1'b0;
                        end else if (state == ST_MEASURE && match_next == LOCK_N) begin
                            state      <= ST_LOCKED;
                            rate_valid <= 1'b1;
                            rate_code  <= cls.code;
                        end
                    end else if (cnt_inc == TIMEOUT) begin
                        state      <= ST_IDLE;
                        rate_valid <= 1'b0;
                        rate_err   <= 1'b1;
                        meas_stb   <= 1'b1;
                        match_cnt  <= '0;
                    end
                end
            endcase
        end
    end

endmodule
